// File: rtl/mips_single_cycle_cpu.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : mips_single_cycle_cpu                                         |
// | Single-cycle 32-bit MIPS subset CPU with internal IMEM, DMEM, RF, HI/LO |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+

module mips_imem #(
    parameter int WORDS = 128,
    parameter int AW    = $clog2(WORDS)
) (
    input  wire logic [AW-1:0] i_addr,
    output logic      [31:0]   o_data
);
    logic [31:0] mem_array [0:WORDS-1];

    assign o_data = mem_array[i_addr];
endmodule

module mips_dmem #(
    parameter int WORDS = 128,
    parameter int AW    = $clog2(WORDS)
) (
    input  wire logic          clk,
    input  wire logic          i_we,
    input  wire logic [AW-1:0] i_addr,
    input  wire logic [31:0]   i_wdata,
    output logic      [31:0]   o_rdata
);
    logic [31:0] mem_array [0:WORDS-1];

    assign o_rdata = mem_array[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) mem_array[i_addr] <= i_wdata;
    end
endmodule

module mips_regfile (
    input  wire logic        clk,
    input  wire logic        i_we,
    input  wire logic [4:0]  i_wa,
    input  wire logic [31:0] i_wd,
    input  wire logic [4:0]  i_ra1,
    input  wire logic [4:0]  i_ra2,
    output logic      [31:0]  o_rd1,
    output logic      [31:0]  o_rd2
);
    logic [31:0] file_array [0:31];

    assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : file_array[i_ra1];
    assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : file_array[i_ra2];

    always_ff @(posedge clk) begin
        if (i_we && (i_wa != 5'd0)) file_array[i_wa] <= i_wd;
    end
endmodule

module mips_single_cycle_cpu #(
    parameter int IMEM_WORDS = 128,
    parameter int DMEM_WORDS = 128
) (
    input wire logic clk,
    input wire logic rst
);
    localparam int c_IAW = $clog2(IMEM_WORDS);
    localparam int c_DAW = $clog2(DMEM_WORDS);

    localparam logic [5:0] c_OP_RTYPE = 6'd0;
    localparam logic [5:0] c_OP_J     = 6'd2;
    localparam logic [5:0] c_OP_BEQ   = 6'd4;
    localparam logic [5:0] c_OP_ANDI  = 6'd12;
    localparam logic [5:0] c_OP_LW    = 6'd35;
    localparam logic [5:0] c_OP_SW    = 6'd43;

    localparam logic [5:0] c_FN_SLL   = 6'd0;
    localparam logic [5:0] c_FN_JR    = 6'd8;
    localparam logic [5:0] c_FN_MFHI  = 6'd16;
    localparam logic [5:0] c_FN_MFLO  = 6'd18;
    localparam logic [5:0] c_FN_MULTU = 6'd25;
    localparam logic [5:0] c_FN_ADD   = 6'd32;
    localparam logic [5:0] c_FN_SUB   = 6'd34;
    localparam logic [5:0] c_FN_AND   = 6'd36;
    localparam logic [5:0] c_FN_OR    = 6'd37;

    logic [31:0] pc;
    logic [31:0] out_instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] rfile_wd;

    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [4:0]  w_rs, w_rt, w_rd, w_shamt, w_rf_wa;
    logic [31:0] w_rs_val, w_rt_val, w_sext, w_zext, w_pc4, w_next_pc;
    logic [31:0] w_mem_addr, w_mem_rdata;
    logic [63:0] w_prod;
    logic        w_rf_we, w_mem_we, w_hilo_we;
    logic        w_unused_addr;

    assign opcode  = out_instr[31:26];
    assign funct   = out_instr[5:0];
    assign w_rs    = out_instr[25:21];
    assign w_rt    = out_instr[20:16];
    assign w_rd    = out_instr[15:11];
    assign w_shamt = out_instr[10:6];
    assign w_sext  = {{16{out_instr[15]}}, out_instr[15:0]};
    assign w_zext  = {16'd0, out_instr[15:0]};
    assign w_pc4   = pc + 32'd4;

    assign w_mem_addr    = w_rs_val + w_sext;
    assign w_prod        = 64'(w_rs_val) * 64'(w_rt_val);
    assign w_unused_addr = ^{w_mem_addr[31:c_DAW+2], w_mem_addr[1:0]};

    mips_imem #(.WORDS(IMEM_WORDS)) InstrMem (
        .i_addr (pc[c_IAW+1:2]),
        .o_data (out_instr)
    );

    mips_dmem #(.WORDS(DMEM_WORDS)) DatMem (
        .clk     (clk),
        .i_we    (w_mem_we & ~rst),
        .i_addr  (w_mem_addr[c_DAW+1:2]),
        .i_wdata (w_rt_val),
        .o_rdata (w_mem_rdata)
    );

    mips_regfile RegFile (
        .clk   (clk),
        .i_we  (w_rf_we & ~rst),
        .i_wa  (w_rf_wa),
        .i_wd  (rfile_wd),
        .i_ra1 (w_rs),
        .i_ra2 (w_rt),
        .o_rd1 (w_rs_val),
        .o_rd2 (w_rt_val)
    );

    // Decode: anything not matched falls through to a plain pc+4 with no writes.
    always_comb begin
        w_rf_we   = 1'b0;
        w_rf_wa   = w_rd;
        rfile_wd  = 32'd0;
        w_mem_we  = 1'b0;
        w_hilo_we = 1'b0;
        w_next_pc = w_pc4;
        case (opcode)
            c_OP_RTYPE: begin
                case (funct)
                    c_FN_ADD:   begin w_rf_we = 1'b1; rfile_wd = w_rs_val + w_rt_val; end
                    c_FN_SUB:   begin w_rf_we = 1'b1; rfile_wd = w_rs_val - w_rt_val; end
                    c_FN_AND:   begin w_rf_we = 1'b1; rfile_wd = w_rs_val & w_rt_val; end
                    c_FN_OR:    begin w_rf_we = 1'b1; rfile_wd = w_rs_val | w_rt_val; end
                    c_FN_SLL:   begin w_rf_we = 1'b1; rfile_wd = w_rt_val << w_shamt; end
                    c_FN_MFHI:  begin w_rf_we = 1'b1; rfile_wd = r_hi; end
                    c_FN_MFLO:  begin w_rf_we = 1'b1; rfile_wd = r_lo; end
                    c_FN_MULTU: w_hilo_we = 1'b1;
                    c_FN_JR:    w_next_pc = w_rs_val;
                    default:    ;
                endcase
            end
            c_OP_ANDI: begin
                w_rf_we  = 1'b1;
                w_rf_wa  = w_rt;
                rfile_wd = w_rs_val & w_zext;
            end
            c_OP_LW: begin
                w_rf_we  = 1'b1;
                w_rf_wa  = w_rt;
                rfile_wd = w_mem_rdata;
            end
            c_OP_SW:  w_mem_we = 1'b1;
            c_OP_BEQ: begin
                if (w_rs_val == w_rt_val) w_next_pc = w_pc4 + {w_sext[29:0], 2'b00};
            end
            c_OP_J:   w_next_pc = {w_pc4[31:28], out_instr[25:0], 2'b00};
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc   <= 32'd0;
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else begin
            pc <= w_next_pc;
            if (w_hilo_we) begin
                r_hi <= w_prod[63:32];
                r_lo <= w_prod[31:0];
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_mips_single_cycle_cpu.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_mips_single_cycle_cpu                                      |
// | Directed program with per-cycle pc/write-data scoreboard               |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_mips_single_cycle_cpu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;

    typedef struct {
        logic [31:0] pc;
        bit          chk_wd;
        logic [31:0] wd;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    mips_single_cycle_cpu dut (.clk(clk), .rst(rst));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rtype(input int rs, rt, rd, sh, fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction
    function automatic logic [31:0] itype(input int op, rs, rt, input logic [15:0] imm);
        return {6'(op), 5'(rs), 5'(rt), imm};
    endfunction
    function automatic logic [31:0] jtype(input int op, input logic [25:0] tgt);
        return {6'(op), tgt};
    endfunction

    task automatic expect_cycle(input logic [31:0] p, input bit cw, input logic [31:0] w);
        exp_t e;
        e.pc = p; e.chk_wd = cw; e.wd = w;
        q.push_back(e);
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en && !rst && q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pc", dut.pc, e.pc);
            if (e.chk_wd) chk("rfile_wd", dut.rfile_wd, e.wd);
        end
    end

    initial begin
        for (int i = 0; i < 128; i++) begin
            dut.InstrMem.mem_array[i] = 32'd0;
            dut.DatMem.mem_array[i]   = 32'd0;
        end
        for (int i = 0; i < 32; i++) dut.RegFile.file_array[i] = 32'd0;
        dut.RegFile.file_array[1] = 32'd5;
        dut.RegFile.file_array[2] = 32'd3;
        dut.RegFile.file_array[7] = 32'h48;
        dut.RegFile.file_array[8] = 32'hFFFF_FFFF;
        dut.RegFile.file_array[9] = 32'hFFFF_FFFF;

        dut.InstrMem.mem_array[0]  = rtype(1, 2, 3, 0, 32);           // ADD $3,$1,$2
        dut.InstrMem.mem_array[1]  = rtype(1, 2, 4, 0, 34);           // SUB $4,$1,$2
        dut.InstrMem.mem_array[2]  = itype(4, 1, 1, 16'd2);           // BEQ taken
        dut.InstrMem.mem_array[3]  = rtype(1, 1, 10, 0, 32);          // skipped
        dut.InstrMem.mem_array[4]  = rtype(1, 1, 10, 0, 32);          // skipped
        dut.InstrMem.mem_array[5]  = itype(4, 1, 2, 16'd5);           // BEQ not taken
        dut.InstrMem.mem_array[6]  = rtype(1, 2, 0, 0, 32);           // ADD $0
        dut.InstrMem.mem_array[7]  = rtype(8, 9, 0, 0, 25);           // MULTU
        dut.InstrMem.mem_array[8]  = rtype(0, 0, 11, 0, 16);          // MFHI
        dut.InstrMem.mem_array[9]  = rtype(0, 0, 12, 0, 18);          // MFLO
        dut.InstrMem.mem_array[10] = itype(43, 0, 1, 16'd4);          // SW $1,4($0)
        dut.InstrMem.mem_array[11] = itype(35, 0, 5, 16'd4);          // LW $5,4($0)
        dut.InstrMem.mem_array[12] = itype(12, 1, 6, 16'hFFFF);       // ANDI
        dut.InstrMem.mem_array[13] = rtype(1, 2, 13, 0, 37);          // OR
        dut.InstrMem.mem_array[14] = rtype(0, 1, 15, 3, 0);           // SLL $15,$1,3
        dut.InstrMem.mem_array[15] = jtype(2, 26'h10);                // J -> 0x40
        dut.InstrMem.mem_array[16] = rtype(7, 0, 0, 0, 8);            // JR $7 -> 0x48
        dut.InstrMem.mem_array[17] = rtype(1, 1, 10, 0, 32);          // skipped
        dut.InstrMem.mem_array[18] = rtype(1, 2, 14, 0, 36);          // AND
        dut.InstrMem.mem_array[19] = itype(63, 1, 17, 16'h1234);      // undefined opcode
        dut.InstrMem.mem_array[20] = rtype(1, 2, 16, 0, 63);          // undefined funct
        dut.InstrMem.mem_array[21] = jtype(2, 26'h15);                // J self

        expect_cycle(32'h00, 1, 32'd8);
        expect_cycle(32'h04, 1, 32'd2);
        expect_cycle(32'h08, 0, 32'd0);
        expect_cycle(32'h14, 0, 32'd0);
        expect_cycle(32'h18, 1, 32'd8);
        expect_cycle(32'h1C, 0, 32'd0);
        expect_cycle(32'h20, 1, 32'hFFFF_FFFE);
        expect_cycle(32'h24, 1, 32'h0000_0001);
        expect_cycle(32'h28, 0, 32'd0);
        expect_cycle(32'h2C, 1, 32'd5);
        expect_cycle(32'h30, 1, 32'd5);
        expect_cycle(32'h34, 1, 32'd7);
        expect_cycle(32'h38, 1, 32'd40);
        expect_cycle(32'h3C, 0, 32'd0);
        expect_cycle(32'h40, 0, 32'd0);
        expect_cycle(32'h48, 1, 32'd1);
        expect_cycle(32'h4C, 0, 32'd0);
        expect_cycle(32'h50, 0, 32'd0);
        expect_cycle(32'h54, 0, 32'd0);
        expect_cycle(32'h54, 0, 32'd0);

        #1;
        chk("reset_pc", dut.pc, 32'd0);
        chk("reset_hi", dut.r_hi, 32'd0);
        chk("reset_lo", dut.r_lo, 32'd0);
        mon_en = 1'b1;
        #7 rst = 1'b0;

        for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
        chk("sb_drain_left", 32'(q.size()), 32'd0);
        mon_en = 1'b0;

        @(negedge clk);
        chk("r3",   dut.RegFile.file_array[3],  32'd8);
        chk("r4",   dut.RegFile.file_array[4],  32'd2);
        chk("r0",   dut.RegFile.o_rd1 & 32'd0 | ((dut.RegFile.file_array[0] == 32'd0) ? 32'd0 : 32'd1), 32'd0);
        chk("r5",   dut.RegFile.file_array[5],  32'd5);
        chk("r6",   dut.RegFile.file_array[6],  32'd5);
        chk("dm1",  dut.DatMem.mem_array[1],    32'd5);
        chk("r10",  dut.RegFile.file_array[10], 32'd0);
        chk("r11",  dut.RegFile.file_array[11], 32'hFFFF_FFFE);
        chk("r12",  dut.RegFile.file_array[12], 32'd1);
        chk("r14",  dut.RegFile.file_array[14], 32'd1);
        chk("r15",  dut.RegFile.file_array[15], 32'd40);
        chk("r16",  dut.RegFile.file_array[16], 32'd0);
        chk("r17",  dut.RegFile.file_array[17], 32'd0);
        chk("hi",   dut.r_hi, 32'hFFFF_FFFE);

        // Asynchronous reset mid-cycle, then confirm writes are held off.
        #2 rst = 1'b1;
        #1;
        chk("async_pc", dut.pc, 32'd0);
        chk("async_hi", dut.r_hi, 32'd0);
        chk("async_lo", dut.r_lo, 32'd0);
        dut.RegFile.file_array[3] = 32'h1234;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_no_write", dut.RegFile.file_array[3], 32'h1234);
        chk("rst_pc_hold", dut.pc, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_pc", dut.pc, 32'd4);
        chk("post_rst_r3", dut.RegFile.file_array[3], 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
